// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: receive-side bundle from the 8N1 UART receiver to the
// control path and status logic.
//   rcv        one-cycle strobe, data holds a freshly framed byte
//   data       last correctly framed byte (data_uart_t, LSB received first)
//   frame_err  one-cycle strobe, the stop bit sampled low
//   busy       receiver is somewhere other than IDLE
// Modports: master = receiver (drives everything), slave = consumer.
interface uart_rx_8n1_if;
  logic       rcv;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  modport master (output rcv, output data, output frame_err, output busy);
  modport slave  (input rcv, input data, input frame_err, input busy);
endinterface

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 asynchronous serial receiver with mid-bit sampling.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   rx   serial line, idles high, asynchronous to clk
//   bus  uart_rx_8n1_if.master: rcv, data, frame_err, busy
// Parameter CLKS_PER_BIT: clock cycles per bit, even and >= 8.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_8n1_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       sh, sh_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             rcv_q, rcv_nxt;
  logic             ferr_q, ferr_nxt;
  logic             busy_q;
  logic             rx_m, rx_s;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      sh      <= sh_nxt;
      data_q  <= data_nxt;
      rcv_q   <= rcv_nxt;
      ferr_q  <= ferr_nxt;
      // Registered from the next state so busy tracks state != IDLE exactly.
      busy_q  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    sh_nxt      = sh;
    data_nxt    = data_q;
    rcv_nxt     = 1'b0;
    ferr_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end

      START: begin
        // Half a bit in: confirm the start bit is still low.
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          sh_nxt      = {rx_s, sh[7:1]};
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        // Deciding mid stop bit puts us back in IDLE half a bit early,
        // so a start edge right after the stop bit is never missed.
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = sh;
            rcv_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // Hold off through a break so a low line cannot start bogus frames.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rcv       = rcv_q;
  assign bus.data      = data_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed bench for uart_rx_8n1 with CLKS_PER_BIT=16.
// Inputs change 1 ns after a rising edge; outputs are checked there too,
// and a negedge monitor logs strobes.
module tb_uart_rx_8n1;

  localparam int unsigned CPB = 16;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log.
  logic [7:0] rcv_data_q[$];
  int         rcv_cyc_q[$];
  int         ferr_cnt = 0;
  int         busy_cycles = 0;
  int         viol = 0;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rcv) begin
        rcv_data_q.push_back(bus.data);
        rcv_cyc_q.push_back(cyc);
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.busy) busy_cycles++;
      if ((bus.rcv && bus.frame_err) || ((bus.rcv || bus.frame_err) && prev_strobe))
        viol++;
      prev_strobe = bus.rcv || bus.frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fall_cyc;

  task automatic send_frame(input logic [7:0] b, input int len, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    wait_cycles(len);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(len);
    end
    rx = stop;
    wait_cycles(len);
  endtask

  int n0, f0, b0, lat;
  int falls[3];

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    check("reset_rcv",  {31'd0, bus.rcv}, 32'd0);
    check("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_data", {24'd0, bus.data}, 32'h00);
    rst = 1'b0;
    wait_cycles(5);

    // Single 'A': strobe 2 sync + 1 IDLE->START + 8 half bit + 9*16 later.
    n0 = rcv_data_q.size();
    f0 = ferr_cnt;
    send_frame(8'h41, CPB, 1'b1);
    wait_cycles(20);
    check("a_count", rcv_data_q.size(), n0 + 1);
    check("a_data",  {24'd0, bus.data}, 32'h41);
    check("a_ferr",  ferr_cnt, f0);
    lat = rcv_cyc_q[n0] - fall_cyc;
    check("a_latency_in_154_156", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);

    // Back-to-back "3,7" with no idle gap.
    n0 = rcv_data_q.size();
    send_frame(8'h33, CPB, 1'b1); falls[0] = fall_cyc;
    send_frame(8'h2C, CPB, 1'b1); falls[1] = fall_cyc;
    send_frame(8'h37, CPB, 1'b1); falls[2] = fall_cyc;
    wait_cycles(20);
    check("b2b_falls_spacing", falls[2] - falls[0], 320);
    check("b2b_count", rcv_data_q.size(), n0 + 3);
    check("b2b_data0", {24'd0, rcv_data_q[n0]},     32'h33);
    check("b2b_data1", {24'd0, rcv_data_q[n0 + 1]}, 32'h2C);
    check("b2b_data2", {24'd0, rcv_data_q[n0 + 2]}, 32'h37);
    check("b2b_gap01", rcv_cyc_q[n0 + 1] - rcv_cyc_q[n0],     160);
    check("b2b_gap12", rcv_cyc_q[n0 + 2] - rcv_cyc_q[n0 + 1], 160);
    check("b2b_final_data", {24'd0, bus.data}, 32'h37);

    // 5-cycle glitch: start check fails, back to IDLE after 2+1+8 cycles.
    n0 = rcv_data_q.size();
    f0 = ferr_cnt;
    b0 = busy_cycles;
    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_cycles(7);
    check("glitch_busy_cleared", {31'd0, bus.busy}, 32'd0);
    check("glitch_busy_seen", {31'd0, (busy_cycles > b0)}, 32'd1);
    wait_cycles(20);
    check("glitch_no_rcv",  rcv_data_q.size(), n0);
    check("glitch_no_ferr", ferr_cnt, f0);

    // Stop bit low, then line held low (break).
    n0 = rcv_data_q.size();
    f0 = ferr_cnt;
    send_frame(8'h55, CPB, 1'b0);
    wait_cycles(40);
    check("ferr_count", ferr_cnt, f0 + 1);
    check("ferr_no_rcv", rcv_data_q.size(), n0);
    check("ferr_data_kept", {24'd0, bus.data}, 32'h37);
    check("ferr_busy_in_break", {31'd0, bus.busy}, 32'd1);
    rx = 1'b1;
    wait_cycles(4);
    check("ferr_busy_after_break", {31'd0, bus.busy}, 32'd0);
    wait_cycles(10);
    send_frame(8'h0D, CPB, 1'b1);
    wait_cycles(20);
    check("after_ferr_count", rcv_data_q.size(), n0 + 1);
    check("after_ferr_data", {24'd0, bus.data}, 32'h0D);

    // Reset in the middle of data bit 4 of 8'hFF.
    n0 = rcv_data_q.size();
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_cycles(CPB);
    end
    rx = 1'b1;
    wait_cycles(CPB / 2);
    rst = 1'b1;
    #1;
    check("midrst_rcv",  {31'd0, bus.rcv}, 32'd0);
    check("midrst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_data", {24'd0, bus.data}, 32'h00);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3 * CPB);
    check("midrst_no_rcv", rcv_data_q.size(), n0);
    send_frame(8'hA5, CPB, 1'b1);
    wait_cycles(20);
    check("midrst_next_count", rcv_data_q.size(), n0 + 1);
    check("midrst_next_data", {24'd0, bus.data}, 32'hA5);

    // Baud skew: 15- and 17-cycle bits.
    n0 = rcv_data_q.size();
    send_frame(8'hC3, 15, 1'b1);
    wait_cycles(30);
    check("skew15_count", rcv_data_q.size(), n0 + 1);
    check("skew15_data", {24'd0, bus.data}, 32'hC3);
    send_frame(8'hC3, 17, 1'b1);
    wait_cycles(30);
    check("skew17_count", rcv_data_q.size(), n0 + 2);
    check("skew17_data", {24'd0, rcv_data_q[n0 + 1]}, 32'hC3);

    check("strobe_exclusive_nonconsecutive", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
